// File: rtl/pcm_sample_buffer.sv
// PCM sample buffer: stereo-to-mono mix, gain with saturation, and a small
// FIFO that pops one sample per PWM frame onto a held DAC input.
module pcm_sample_buffer #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 256,
  parameter int POP_PHASE = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [15:0]                snd_left,
  input  logic [15:0]                snd_right,
  input  logic                       snd_sample,
  input  logic [1:0]                 gain,
  input  logic                       mute,
  input  logic                       clr_flags,
  output logic [15:0]                pcm_out,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       underrun,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(FRAME_LEN);

  logic signed [16:0] sum_q, sum_d;
  logic               v1_q;
  logic        [15:0] res_q, res_d;
  logic               v2_q;
  logic      [CW-1:0] cnt_q, cnt_d;
  logic      [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic      [LW-1:0] lvl_q, lvl_d;
  logic        [15:0] pcm_q, pcm_d;
  logic               und_q, und_d;
  logic               ovr_q, ovr_d;
  logic        [15:0] mem_q [DEPTH];

  logic signed [15:0] mix;
  logic signed [18:0] shf;
  logic               pop, full, empty, do_pop, do_wr;

  always_comb begin
    sum_d = {snd_left[15], snd_left} + {snd_right[15], snd_right};
    mix   = 16'(sum_q >>> 1);
    shf   = {{3{mix[15]}}, mix} <<< gain;
    if (shf > 19'sh07FFF)      res_d = 16'h7FFF;
    else if (shf < 19'sh78000) res_d = 16'h8000;
    else                       res_d = shf[15:0];
    if (mute) res_d = 16'h0000;
  end

  // Full/empty come from the occupancy count, so pointer equality is unambiguous.
  always_comb begin
    cnt_d  = (cnt_q == CW'(FRAME_LEN - 1)) ? '0 : cnt_q + CW'(1);
    pop    = (cnt_q == CW'(POP_PHASE));
    full   = (lvl_q == LW'(DEPTH));
    empty  = (lvl_q == '0);
    do_pop = pop & ~empty;
    do_wr  = v2_q & (~full | do_pop);
    wp_d   = do_wr  ? wp_q + AW'(1) : wp_q;
    rp_d   = do_pop ? rp_q + AW'(1) : rp_q;
    lvl_d  = lvl_q + LW'(do_wr) - LW'(do_pop);
    pcm_d  = do_pop ? mem_q[rp_q] : pcm_q;
    und_d  = (pop & empty) | (und_q & ~clr_flags);
    ovr_d  = (v2_q & ~do_wr) | (ovr_q & ~clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      v1_q  <= 1'b0;
      res_q <= '0;
      v2_q  <= 1'b0;
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      pcm_q <= '0;
      und_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (snd_sample) sum_q <= sum_d;
      v1_q  <= snd_sample;
      if (v1_q) res_q <= res_d;
      v2_q  <= v1_q;
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
      pcm_q <= pcm_d;
      und_q <= und_d;
      ovr_q <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wp_q] <= res_q;
  end

  assign pcm_out  = pcm_q;
  assign level    = lvl_q;
  assign underrun = und_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_pcm_sample_buffer.sv
// Bench for pcm_sample_buffer: queue-based reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_pcm_sample_buffer;
  localparam int DEPTH = 8;
  localparam int FLEN  = 256;
  localparam int POP   = 128;

  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] snd_left = 0, snd_right = 0;
  logic        snd_sample = 0;
  logic [1:0]  gain = 0;
  logic        mute = 0;
  logic        clr_flags = 0;
  logic [15:0] pcm_out;
  logic [3:0]  level;
  logic        underrun, overrun;

  int total = 0;
  int bad = 0;

  pcm_sample_buffer #(.DEPTH(DEPTH), .FRAME_LEN(FLEN), .POP_PHASE(POP)) dut (
    .clk(clk), .rst(rst),
    .snd_left(snd_left), .snd_right(snd_right), .snd_sample(snd_sample),
    .gain(gain), .mute(mute), .clr_flags(clr_flags),
    .pcm_out(pcm_out), .level(level),
    .underrun(underrun), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a sample queue plus pending pipeline entries keyed by edge.
  logic [15:0] q[$];
  int          s1[int];
  int          w2[int];
  int          mpos = 0;
  int          ncyc = 0;
  logic [15:0] mpcm = 0;
  logic        mund = 0, movr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete(); s1.delete(); w2.delete();
      mpos = 0; ncyc = 0; mpcm = 0; mund = 0; movr = 0;
    end else begin
      int sz, l, r, m, v;
      bit popd, su, so;
      sz = q.size(); popd = 0; su = 0; so = 0;
      if (mpos == POP) begin
        if (sz > 0) begin mpcm = q.pop_front(); popd = 1; end
        else su = 1;
      end
      if (w2.exists(ncyc)) begin
        if (sz < DEPTH || popd) q.push_back(16'(w2[ncyc]));
        else so = 1;
        w2.delete(ncyc);
      end
      if (s1.exists(ncyc)) begin
        m = s1[ncyc] >>> 1;
        v = m * (1 << gain);
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        if (mute) v = 0;
        w2[ncyc + 1] = v;
        s1.delete(ncyc);
      end
      if (snd_sample) begin
        l = $signed(snd_left);
        r = $signed(snd_right);
        s1[ncyc + 1] = l + r;
      end
      mund = su | (mund & !clr_flags);
      movr = so | (movr & !clr_flags);
      mpos = (mpos + 1) % FLEN;
      ncyc++;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("model pcm_out", 32'(pcm_out), 32'(mpcm));
      chk("model level", 32'(level), 32'(q.size()));
      chk("model underrun", 32'(underrun), 32'(mund));
      chk("model overrun", 32'(overrun), 32'(movr));
    end
  end

  task automatic goto_pos(int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mpos != p && n < 600);
    if (mpos != p) chk("goto_pos timeout", 32'(mpos), 32'(p));
  endtask

  task automatic strobe(logic [15:0] l, logic [15:0] r);
    snd_left = l; snd_right = r; snd_sample = 1;
    @(negedge clk);
    snd_sample = 0;
  endtask

  task automatic clr_pulse();
    clr_flags = 1;
    @(negedge clk);
    clr_flags = 0;
  endtask

  task automatic sat_case(string nm, logic [15:0] l, logic [15:0] r,
                          logic [1:0] g, logic mu, logic [15:0] exp);
    goto_pos(10);
    gain = g; mute = mu;
    strobe(l, r);
    goto_pos(129);
    chk(nm, 32'(pcm_out), 32'(exp));
    gain = 0; mute = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset pcm_out", 32'(pcm_out), 0);
    chk("reset level", 32'(level), 0);
    chk("reset underrun", 32'(underrun), 0);
    chk("reset overrun", 32'(overrun), 0);
    rst = 0;

    goto_pos(129);
    chk("idle first pop underrun", 32'(underrun), 1);
    chk("idle pcm_out", 32'(pcm_out), 0);
    goto_pos(129);
    goto_pos(129);
    chk("idle 3 frames pcm_out", 32'(pcm_out), 0);
    chk("idle 3 frames level", 32'(level), 0);

    goto_pos(10);
    clr_pulse();
    strobe(16'h1000, 16'h3000);
    @(negedge clk);
    @(negedge clk);
    chk("single level after 2", 32'(level), 1);
    goto_pos(129);
    chk("single pcm_out", 32'(pcm_out), 32'h2000);
    chk("single level popped", 32'(level), 0);

    sat_case("sat positive", 16'h7000, 16'h7000, 2'd2, 1'b0, 16'h7FFF);
    sat_case("sat negative", 16'h9000, 16'h9000, 2'd1, 1'b0, 16'h8000);
    sat_case("cancel zero", 16'h0100, 16'hFF00, 2'd3, 1'b0, 16'h0000);
    sat_case("odd mix", 16'h0003, 16'h0000, 2'd1, 1'b0, 16'h0002);
    sat_case("mute", 16'h4000, 16'h4000, 2'd0, 1'b1, 16'h0000);

    goto_pos(130);
    clr_pulse();
    for (int n = 1; n <= 10; n++) begin
      snd_left = 16'(n); snd_right = 16'(n); snd_sample = 1;
      @(negedge clk);
    end
    snd_sample = 0;
    repeat (3) @(negedge clk);
    chk("burst level full", 32'(level), 8);
    chk("burst overrun", 32'(overrun), 1);
    for (int k = 1; k <= 8; k++) begin
      goto_pos(129);
      chk("burst pop order", 32'(pcm_out), 32'(k));
    end
    clr_pulse();
    goto_pos(129);
    chk("burst drained underrun", 32'(underrun), 1);
    chk("burst held pcm_out", 32'(pcm_out), 8);

    goto_pos(10);
    clr_pulse();
    for (int n = 21; n <= 28; n++) begin
      snd_left = 16'(n); snd_right = 16'(n); snd_sample = 1;
      @(negedge clk);
    end
    snd_sample = 0;
    goto_pos(126);
    strobe(16'd30, 16'd30);
    goto_pos(129);
    chk("full+pop overrun", 32'(overrun), 0);
    chk("full+pop level", 32'(level), 8);
    chk("full+pop pcm_out", 32'(pcm_out), 21);
    for (int k = 22; k <= 28; k++) begin
      goto_pos(129);
      chk("full+pop order", 32'(pcm_out), 32'(k));
    end
    goto_pos(129);
    chk("late sample popped", 32'(pcm_out), 30);
    chk("late sample level", 32'(level), 0);

    goto_pos(10);
    for (int n = 41; n <= 45; n++) begin
      snd_left = 16'(n); snd_right = 16'(n); snd_sample = 1;
      @(negedge clk);
    end
    snd_sample = 0;
    goto_pos(60);
    chk("pre-reset level", 32'(level), 5);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async rst pcm_out", 32'(pcm_out), 0);
    chk("async rst level", 32'(level), 0);
    chk("async rst underrun", 32'(underrun), 0);
    chk("async rst overrun", 32'(overrun), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    goto_pos(129);
    chk("post-reset underrun", 32'(underrun), 1);
    chk("post-reset pcm_out", 32'(pcm_out), 0);
    chk("post-reset level", 32'(level), 0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
